bf_issue_ctrl: RTL and testbench

Front-end issue stage for the butterfly (PDEP) permutation network. It accepts header words with their four per-quadrant rule addresses over a valid/ready handshake. It drives the network's address and data inputs, with each address leading its data by the config-RAM read latency. The network has no backpressure, so the block meters issue with a credit counter that the downstream output buffer replenishes.

---
 rtl/bf_pkg.sv | 35 +++
 rtl/bf_delay_line.sv | 32 +++
 rtl/bf_issue_ctrl.sv | 108 ++++++++++
 tb/tb_bf_issue_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Shared definitions for the butterfly network issue front end:
// config-RAM read latency and rule-address field helpers.
package bf_pkg;

  // Must equal the config RAM read latency of the network.
  localparam int BF_ADDR_LEAD = 2;

  localparam int BF_MAX_ADDR_W = 8;
  localparam int BF_ADDR_EXT_W = 4 * BF_MAX_ADDR_W;

  // Quadrant q: 0 = A (MSB field), 1 = B, 2 = C, 3 = D.
  function automatic logic [BF_MAX_ADDR_W-1:0] quad_field(
    input logic [BF_ADDR_EXT_W-1:0] addr,
    input int                       aw,
    input int                       q
  );
    logic [BF_ADDR_EXT_W-1:0] sh;
    sh = addr >> ((3 - q) * aw);
    return sh[BF_MAX_ADDR_W-1:0] & BF_MAX_ADDR_W'((1 << aw) - 1);
  endfunction

  function automatic logic addr_legal(
    input logic [BF_ADDR_EXT_W-1:0] addr,
    input int                       aw,
    input int                       depth
  );
    logic ok;
    ok = 1'b1;
    for (int q = 0; q < 4; q++) begin
      if (int'(quad_field(addr, aw, q)) >= depth) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bf_delay_line.sv
// Fixed-latency shift register for {valid, data}; only the valid bit
// (MSB) is reset so the wide data stages stay reset-free.
module bf_delay_line #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0] r_vld;
  logic [WIDTH-2:0] r_dat [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_d[WIDTH-1];
      for (int i = 1; i < DEPTH; i++) r_vld[i] <= r_vld[i-1];
    end
  end

  always_ff @(posedge clk) begin
    r_dat[0] <= i_d[WIDTH-2:0];
    for (int i = 1; i < DEPTH; i++) r_dat[i] <= r_dat[i-1];
  end

  assign o_q = {r_vld[DEPTH-1], r_dat[DEPTH-1]};

endmodule

// File: rtl/bf_issue_ctrl.sv
// Issue stage for the butterfly permutation network: credit-metered
// handshake, illegal-rule drop, and address-leads-data alignment.
module bf_issue_ctrl
  import bf_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2,
  parameter int CFG_DEPTH  = 3,
  parameter int ADDR_LEAD  = BF_ADDR_LEAD,
  parameter int CREDITS    = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic [4*ADDR_WIDTH-1:0]        s_addr,
  input  logic                           cr_ret,
  output logic [ADDR_WIDTH-1:0]          bf_addr_A,
  output logic [ADDR_WIDTH-1:0]          bf_addr_B,
  output logic [ADDR_WIDTH-1:0]          bf_addr_C,
  output logic [ADDR_WIDTH-1:0]          bf_addr_D,
  output logic                           bf_dval,
  output logic [DATA_WIDTH-1:0]          bf_data,
  output logic [$clog2(CREDITS+1)-1:0]   credit_cnt,
  output logic [CNT_WIDTH-1:0]           drop_cnt,
  output logic                           cr_ovf
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CR_FULL = CW'(CREDITS);
  localparam logic [CW-1:0] CR_ONE  = CW'(1);

  logic [CW-1:0]            r_credit;
  logic [CNT_WIDTH-1:0]     r_drop;
  logic                     r_ovf;
  logic [ADDR_WIDTH-1:0]    r_addr_a, r_addr_b, r_addr_c, r_addr_d;
  logic                     r_vld_p0;
  logic [DATA_WIDTH-1:0]    r_data_p0;
  logic [BF_ADDR_EXT_W-1:0] w_addr_ext;
  logic                     w_legal, w_accept, w_issue, w_drop;
  logic [DATA_WIDTH:0]      w_dl_q;

  assign w_addr_ext = BF_ADDR_EXT_W'(s_addr);
  assign w_legal    = addr_legal(w_addr_ext, ADDR_WIDTH, CFG_DEPTH);
  assign s_ready    = (r_credit != '0);
  assign w_accept   = s_valid && s_ready;
  assign w_issue    = w_accept && w_legal;
  assign w_drop     = w_accept && !w_legal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_credit <= CR_FULL;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_addr_c <= '0;
      r_addr_d <= '0;
      r_vld_p0 <= 1'b0;
    end else begin
      r_vld_p0 <= w_issue;
      case ({w_issue, cr_ret})
        2'b10: r_credit <= r_credit - CR_ONE;
        2'b01: begin
          if (r_credit == CR_FULL) r_ovf <= 1'b1;
          else                     r_credit <= r_credit + CR_ONE;
        end
        default: ;
      endcase
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + CNT_WIDTH'(1);
      if (w_issue) begin
        r_addr_a <= ADDR_WIDTH'(quad_field(w_addr_ext, ADDR_WIDTH, 0));
        r_addr_b <= ADDR_WIDTH'(quad_field(w_addr_ext, ADDR_WIDTH, 1));
        r_addr_c <= ADDR_WIDTH'(quad_field(w_addr_ext, ADDR_WIDTH, 2));
        r_addr_d <= ADDR_WIDTH'(quad_field(w_addr_ext, ADDR_WIDTH, 3));
      end
    end
  end

  // Stage p0: issued data captured alongside its address.
  always_ff @(posedge clk) begin
    if (w_issue) r_data_p0 <= s_data;
  end

  // Stages p1..pADDR_LEAD: data trails the address by the RAM latency.
  bf_delay_line #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (ADDR_LEAD)
  ) u_dly (
    .clk (clk),
    .rst (rst),
    .i_d ({r_vld_p0, r_data_p0}),
    .o_q (w_dl_q)
  );

  assign bf_dval    = w_dl_q[DATA_WIDTH];
  assign bf_data    = bf_dval ? w_dl_q[DATA_WIDTH-1:0] : '0;
  assign bf_addr_A  = r_addr_a;
  assign bf_addr_B  = r_addr_b;
  assign bf_addr_C  = r_addr_c;
  assign bf_addr_D  = r_addr_d;
  assign credit_cnt = r_credit;
  assign drop_cnt   = r_drop;
  assign cr_ovf     = r_ovf;

endmodule

// File: tb/tb_bf_issue_ctrl.sv
// Directed bench for bf_issue_ctrl with default parameters.
module tb_bf_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst, s_valid, s_ready, cr_ret;
  logic [15:0] s_data;
  logic [7:0]  s_addr;
  logic [1:0]  bf_addr_A, bf_addr_B, bf_addr_C, bf_addr_D;
  logic        bf_dval;
  logic [15:0] bf_data;
  logic [3:0]  credit_cnt;
  logic [15:0] drop_cnt;
  logic        cr_ovf;

  int n_cmp = 0;
  int n_err = 0;

  logic [1:0]  exp_a [8];
  logic [1:0]  exp_b [8];
  logic [1:0]  exp_c [8];
  logic [15:0] exp_d [8];

  always #5 clk = ~clk;

  bf_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_addr     (s_addr),
    .cr_ret     (cr_ret),
    .bf_addr_A  (bf_addr_A),
    .bf_addr_B  (bf_addr_B),
    .bf_addr_C  (bf_addr_C),
    .bf_addr_D  (bf_addr_D),
    .bf_dval    (bf_dval),
    .bf_data    (bf_data),
    .credit_cnt (credit_cnt),
    .drop_cnt   (drop_cnt),
    .cr_ovf     (cr_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; cr_ret = 1'b0; s_data = '0; s_addr = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %0b want 1", s_ready); end
    n_cmp++; if (credit_cnt !== 4'd8) begin n_err++; $display("FAIL rst_credit got %0d want 8", credit_cnt); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL rst_drop got %0d want 0", drop_cnt); end
    n_cmp++; if (cr_ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %0b want 0", cr_ovf); end
    n_cmp++; if ({bf_dval, bf_data} !== 17'd0) begin n_err++; $display("FAIL rst_dval_data got %0b/%h want 0/0000", bf_dval, bf_data); end
    n_cmp++; if ({bf_addr_A, bf_addr_B, bf_addr_C, bf_addr_D} !== 8'd0) begin n_err++;
      $display("FAIL rst_addr got %0d/%0d/%0d/%0d want 0/0/0/0", bf_addr_A, bf_addr_B, bf_addr_C, bf_addr_D); end
  endtask

  task automatic test_single();
    s_valid = 1'b1; s_data = 16'hA5C3; s_addr = 8'b00_01_10_00;
    tick();
    s_valid = 1'b0;
    n_cmp++; if ({bf_addr_A, bf_addr_B, bf_addr_C, bf_addr_D} !== 8'b00_01_10_00) begin n_err++;
      $display("FAIL single_addr got %0d/%0d/%0d/%0d want 0/1/2/0", bf_addr_A, bf_addr_B, bf_addr_C, bf_addr_D); end
    n_cmp++; if (credit_cnt !== 4'd7) begin n_err++; $display("FAIL single_credit got %0d want 7", credit_cnt); end
    for (int c = 1; c <= 4; c++) begin
      n_cmp++;
      if (c == 3) begin
        if (bf_dval !== 1'b1 || bf_data !== 16'hA5C3) begin n_err++;
          $display("FAIL single_dval_c%0d got %0b/%h want 1/a5c3", c, bf_dval, bf_data); end
      end else if (bf_dval !== 1'b0 || bf_data !== 16'h0) begin n_err++;
        $display("FAIL single_dval_c%0d got %0b/%h want 0/0000", c, bf_dval, bf_data); end
      tick();
    end
    cr_ret = 1'b1; tick(); cr_ret = 1'b0;
    n_cmp++; if (credit_cnt !== 4'd8) begin n_err++; $display("FAIL single_return got %0d want 8", credit_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      exp_a[i] = 2'(i % 3); exp_b[i] = 2'((i + 1) % 3); exp_c[i] = 2'((i + 2) % 3);
      exp_d[i] = 16'h1000 + 16'(i);
    end
    for (int c = 0; c < 12; c++) begin
      s_valid = (c < 10);
      s_data  = (c < 8) ? exp_d[c] : 16'hDEAD;
      s_addr  = (c < 8) ? {exp_a[c], exp_b[c], exp_c[c], 2'b00} : 8'h00;
      tick();
      n_cmp++; if (s_ready !== (c + 1 < 8)) begin n_err++;
        $display("FAIL b2b_ready_c%0d got %0b want %0b", c + 1, s_ready, (c + 1 < 8)); end
      if (c < 8) begin
        n_cmp++; if ({bf_addr_A, bf_addr_B, bf_addr_C, bf_addr_D} !== {exp_a[c], exp_b[c], exp_c[c], 2'b00}) begin n_err++;
          $display("FAIL b2b_addr_c%0d got %0d/%0d/%0d/%0d want %0d/%0d/%0d/0", c + 1,
                   bf_addr_A, bf_addr_B, bf_addr_C, bf_addr_D, exp_a[c], exp_b[c], exp_c[c]); end
      end
      n_cmp++;
      if (c + 1 >= 3 && c + 1 <= 10) begin
        if (bf_dval !== 1'b1 || bf_data !== exp_d[c - 2]) begin n_err++;
          $display("FAIL b2b_data_c%0d got %0b/%h want 1/%h", c + 1, bf_dval, bf_data, exp_d[c - 2]); end
      end else if (bf_dval !== 1'b0) begin n_err++;
        $display("FAIL b2b_data_c%0d got dval %0b want 0", c + 1, bf_dval); end
    end
    s_valid = 1'b0;
    n_cmp++; if (credit_cnt !== 4'd0) begin n_err++; $display("FAIL b2b_credit got %0d want 0", credit_cnt); end
    cr_ret = 1'b1; tick(); cr_ret = 1'b0;
    n_cmp++; if (s_ready !== 1'b1 || credit_cnt !== 4'd1) begin n_err++;
      $display("FAIL b2b_return got %0b/%0d want 1/1", s_ready, credit_cnt); end
    cr_ret = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    cr_ret = 1'b0;
    n_cmp++; if (credit_cnt !== 4'd8) begin n_err++; $display("FAIL b2b_refill got %0d want 8", credit_cnt); end
  endtask

  task automatic test_illegal();
    s_valid = 1'b1; s_data = 16'hBEEF; s_addr = 8'b01_00_11_00;
    tick();
    s_valid = 1'b0;
    n_cmp++; if (drop_cnt !== 16'd1) begin n_err++; $display("FAIL illegal_drop got %0d want 1", drop_cnt); end
    n_cmp++; if (credit_cnt !== 4'd8) begin n_err++; $display("FAIL illegal_credit got %0d want 8", credit_cnt); end
    n_cmp++; if ({bf_addr_A, bf_addr_B, bf_addr_C, bf_addr_D} !== {exp_a[7], exp_b[7], exp_c[7], 2'b00}) begin n_err++;
      $display("FAIL illegal_addr got %0d/%0d/%0d/%0d want 1/2/0/0", bf_addr_A, bf_addr_B, bf_addr_C, bf_addr_D); end
    for (int c = 1; c <= 3; c++) begin
      n_cmp++; if (bf_dval !== 1'b0) begin n_err++; $display("FAIL illegal_dval_c%0d got %0b want 0", c, bf_dval); end
      tick();
    end
  endtask

  task automatic test_simultaneous();
    s_valid = 1'b1; s_data = 16'h0123; s_addr = 8'h00;
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (credit_cnt !== 4'd3) begin n_err++; $display("FAIL simul_pre got %0d want 3", credit_cnt); end
    cr_ret = 1'b1;
    tick();
    s_valid = 1'b0; cr_ret = 1'b0;
    n_cmp++; if (credit_cnt !== 4'd3) begin n_err++; $display("FAIL simul_credit got %0d want 3", credit_cnt); end
    cr_ret = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    cr_ret = 1'b0;
    n_cmp++; if (credit_cnt !== 4'd8 || cr_ovf !== 1'b0) begin n_err++;
      $display("FAIL simul_refill got %0d/%0b want 8/0", credit_cnt, cr_ovf); end
  endtask

  task automatic test_overflow();
    cr_ret = 1'b1; tick(); cr_ret = 1'b0;
    n_cmp++; if (credit_cnt !== 4'd8 || cr_ovf !== 1'b1) begin n_err++;
      $display("FAIL ovf_set got %0d/%0b want 8/1", credit_cnt, cr_ovf); end
    s_valid = 1'b1; s_data = 16'h5555; s_addr = 8'b10_10_10_10;
    tick();
    s_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (cr_ovf !== 1'b1 || credit_cnt !== 4'd7) begin n_err++;
      $display("FAIL ovf_sticky got %0b/%0d want 1/7", cr_ovf, credit_cnt); end
    cr_ret = 1'b1; tick(); cr_ret = 1'b0;
    tick();
  endtask

  task automatic test_reset_flush();
    s_valid = 1'b1; s_data = 16'h7777; s_addr = 8'b00_01_00_01;
    tick();
    s_data = 16'h8888;
    tick();
    s_valid = 1'b0;
    n_cmp++; if (credit_cnt !== 4'd6 || drop_cnt !== 16'd1) begin n_err++;
      $display("FAIL flush_pre got %0d/%0d want 6/1", credit_cnt, drop_cnt); end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++; if (credit_cnt !== 4'd8 || drop_cnt !== 16'd0 || cr_ovf !== 1'b0) begin n_err++;
      $display("FAIL flush_state got %0d/%0d/%0b want 8/0/0", credit_cnt, drop_cnt, cr_ovf); end
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (bf_dval !== 1'b0 || bf_data !== 16'h0) begin n_err++;
        $display("FAIL flush_dval_c%0d got %0b/%h want 0/0000", c, bf_dval, bf_data); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_illegal();
    test_simultaneous();
    test_overflow();
    test_reset_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
